imem_arbiter: RTL and testbench

//   Shares one single-port, synchronous-read instruction memory between the CPU fetch

---
 rtl/imem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_imem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: lets the CPU fetch port and the program-loader/debug port share
// one single-port, synchronous-read instruction RAM. Conflicts are resolved
// round-robin. The loader can lock out fetch. Byte PCs become word indices, and
// illegal accesses are answered with an error and never reach the RAM.
module imem_arbiter #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_err,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic          l_err,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    typedef enum logic {
        OWNER_FETCH  = 1'b0,
        OWNER_LOADER = 1'b1
    } owner_e;

    owner_e      rr_last_q, rr_last_d;
    logic        locked_q, locked_d;
    logic        f_rvalid_q, f_rvalid_d, f_err_q, f_err_d;
    logic        l_rvalid_q, l_rvalid_d, l_err_q, l_err_d;
    logic [31:0] f_hold_q, f_hold_d, l_hold_q, l_hold_d;
    logic        f_legal_s, l_legal_s, f_gnt_s, l_gnt_s;
    logic [31:0] f_rdata_s, l_rdata_s;

    // Word-aligned and inside the RAM.
    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(DEPTH));
    endfunction

    assign f_legal_s = addr_legal(f_addr);
    assign l_legal_s = addr_legal(l_addr);

    // Grant decision: nothing during reset, loader-only while locked, else round-robin.
    always_comb begin
        f_gnt_s = 1'b0;
        l_gnt_s = 1'b0;
        if (!rst_n) begin
            f_gnt_s = 1'b0;
            l_gnt_s = 1'b0;
        end else if (locked_q) begin
            l_gnt_s = l_req;
        end else if (f_req && l_req) begin
            case (rr_last_q)
                OWNER_LOADER: f_gnt_s = 1'b1;
                OWNER_FETCH:  l_gnt_s = 1'b1;
                default:      f_gnt_s = 1'b1;
            endcase
        end else begin
            f_gnt_s = f_req;
            l_gnt_s = l_req;
        end
    end

    // Memory port drive; illegal accesses are granted but keep m_en low.
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = {AW{1'b0}};
        m_wdata = l_wdata;
        if (l_gnt_s) begin
            m_addr = l_addr[AW+1:2];
            m_en   = l_legal_s;
            m_we   = l_legal_s & l_we;
        end else if (f_gnt_s) begin
            m_addr = f_addr[AW+1:2];
            m_en   = f_legal_s;
        end else begin
            m_en = 1'b0;
        end
    end

    // Read data shows the RAM output in the response cycle, else the last value.
    always_comb begin
        f_rdata_s = f_hold_q;
        l_rdata_s = l_hold_q;
        if (f_rvalid_q) begin
            f_rdata_s = f_err_q ? 32'h0000_0000 : m_rdata;
        end else begin
            f_rdata_s = f_hold_q;
        end
        if (l_rvalid_q) begin
            l_rdata_s = l_err_q ? 32'h0000_0000 : m_rdata;
        end else begin
            l_rdata_s = l_hold_q;
        end
    end

    // Next-state: round-robin pointer, lock ownership and response flags.
    always_comb begin
        rr_last_d = rr_last_q;
        if (f_req && l_req && !locked_q) begin
            rr_last_d = f_gnt_s ? OWNER_FETCH : OWNER_LOADER;
        end else begin
            rr_last_d = rr_last_q;
        end
        if (locked_q) begin
            locked_d = l_lock;
        end else begin
            locked_d = l_lock & l_gnt_s;
        end
        f_rvalid_d = f_gnt_s;
        f_err_d    = f_gnt_s & ~f_legal_s;
        l_rvalid_d = l_gnt_s & ~l_we;
        l_err_d    = l_gnt_s & ~l_legal_s;
        f_hold_d   = f_rdata_s;
        l_hold_d   = l_rdata_s;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_q  <= OWNER_LOADER;
            locked_q   <= 1'b0;
            f_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            l_rvalid_q <= 1'b0;
            l_err_q    <= 1'b0;
            f_hold_q   <= 32'h0000_0000;
            l_hold_q   <= 32'h0000_0000;
        end else begin
            rr_last_q  <= rr_last_d;
            locked_q   <= locked_d;
            f_rvalid_q <= f_rvalid_d;
            f_err_q    <= f_err_d;
            l_rvalid_q <= l_rvalid_d;
            l_err_q    <= l_err_d;
            f_hold_q   <= f_hold_d;
            l_hold_q   <= l_hold_d;
        end
    end

    assign f_gnt    = f_gnt_s;
    assign l_gnt    = l_gnt_s;
    assign f_rvalid = f_rvalid_q;
    assign f_err    = f_err_q;
    assign f_rdata  = f_rdata_s;
    assign l_rvalid = l_rvalid_q;
    assign l_err    = l_err_q;
    assign l_rdata  = l_rdata_s;

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: table-driven per-cycle vectors plus hand-built
// lock and reset sequences; responses are predicted into a scoreboard queue.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, f_req, l_req, l_we, l_lock;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err, m_en, m_we;
    logic [31:0] f_rdata, l_rdata, m_wdata;
    logic [6:0]  m_addr;
    logic [31:0] m_rdata;

    logic [31:0] mem     [128];
    logic [31:0] ref_mem [128];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst_n;
        logic        f_req;
        logic [31:0] f_addr;
        logic        l_req;
        logic        l_we;
        logic        l_lock;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic        e_fg;
        logic        e_lg;
        logic        e_men;
        logic        e_mwe;
        logic [6:0]  e_maddr;
    } vec_t;

    typedef struct {
        logic        chk;
        logic        f_rv;
        logic        f_er;
        logic [31:0] f_data;
        logic        l_rv;
        logic        l_er;
        logic [31:0] l_data;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] exp_f_hold = 32'h0;
    logic [31:0] exp_l_hold = 32'h0;
    vec_t        tbl[$];

    imem_arbiter #(.DEPTH(128), .AW(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .l_err(l_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read single-port RAM seen by the arbiter.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata <= mem[m_addr];
        end
    end

    function automatic logic tb_legal(input logic [31:0] a);
        return ((a % 32'd4) == 32'd0) && ((a / 32'd4) < 32'd128);
    endfunction

    function automatic vec_t mk(input logic rst, input logic fr, input logic [31:0] fa,
                                input logic lr, input logic lwe, input logic llk,
                                input logic [31:0] la, input logic [31:0] lwd,
                                input logic efg, input logic elg, input logic emen,
                                input logic emwe, input logic [6:0] ema);
        vec_t v;
        v.rst_n = rst; v.f_req = fr; v.f_addr = fa; v.l_req = lr; v.l_we = lwe;
        v.l_lock = llk; v.l_addr = la; v.l_wdata = lwd; v.e_fg = efg; v.e_lg = elg;
        v.e_men = emen; v.e_mwe = emwe; v.e_maddr = ema;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle, check grant/memory outputs and the response due now,
    // then predict the response for the next cycle.
    task automatic apply_vec(input vec_t v, input string tag);
        resp_t r;
        resp_t nr;
        @(negedge clk);
        rst_n = v.rst_n; f_req = v.f_req; f_addr = v.f_addr; l_req = v.l_req;
        l_we = v.l_we; l_lock = v.l_lock; l_addr = v.l_addr; l_wdata = v.l_wdata;
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            r = exp_q.pop_front();
            if (r.chk) begin
                chk({tag, " f_rvalid"}, {31'd0, f_rvalid}, {31'd0, r.f_rv});
                chk({tag, " f_err"},    {31'd0, f_err},    {31'd0, r.f_er});
                chk({tag, " f_rdata"},  f_rdata,           r.f_data);
                chk({tag, " l_rvalid"}, {31'd0, l_rvalid}, {31'd0, r.l_rv});
                chk({tag, " l_err"},    {31'd0, l_err},    {31'd0, r.l_er});
                chk({tag, " l_rdata"},  l_rdata,           r.l_data);
            end
        end
        chk({tag, " f_gnt"}, {31'd0, f_gnt}, {31'd0, v.e_fg});
        chk({tag, " l_gnt"}, {31'd0, l_gnt}, {31'd0, v.e_lg});
        chk({tag, " m_en"},  {31'd0, m_en},  {31'd0, v.e_men});
        chk({tag, " m_we"},  {31'd0, m_we},  {31'd0, v.e_mwe});
        if (v.e_men) chk({tag, " m_addr"}, {25'd0, m_addr}, {25'd0, v.e_maddr});
        if (v.e_mwe) chk({tag, " m_wdata"}, m_wdata, v.l_wdata);

        nr.chk = 1'b1; nr.f_rv = 1'b0; nr.f_er = 1'b0; nr.l_rv = 1'b0; nr.l_er = 1'b0;
        if (!v.rst_n) begin
            exp_f_hold = 32'h0;
            exp_l_hold = 32'h0;
        end else begin
            if (v.e_fg) begin
                nr.f_rv = 1'b1;
                nr.f_er = !tb_legal(v.f_addr);
                exp_f_hold = nr.f_er ? 32'h0 : ref_mem[v.f_addr[8:2]];
            end
            if (v.e_lg) begin
                if (!v.l_we) begin
                    nr.l_rv = 1'b1;
                    nr.l_er = !tb_legal(v.l_addr);
                    exp_l_hold = nr.l_er ? 32'h0 : ref_mem[v.l_addr[8:2]];
                end else begin
                    nr.l_er = !tb_legal(v.l_addr);
                    if (tb_legal(v.l_addr)) ref_mem[v.l_addr[8:2]] = v.l_wdata;
                end
            end
        end
        nr.f_data = exp_f_hold;
        nr.l_data = exp_l_hold;
        exp_q.push_back(nr);
    endtask

    initial begin
        resp_t first;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
            ref_mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
        end
        m_rdata = 32'h0;
        rst_n = 1'b0; f_req = 1'b1; f_addr = 32'h10; l_req = 1'b0; l_we = 1'b0;
        l_lock = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
        first.chk = 1'b0; first.f_rv = 1'b0; first.f_er = 1'b0; first.f_data = 32'h0;
        first.l_rv = 1'b0; first.l_er = 1'b0; first.l_data = 32'h0;
        exp_q.push_back(first);

        // Reset with a pending fetch request: never granted.
        apply_vec(mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 7'd0), "rst0");
        apply_vec(mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 7'd0), "rst1");

        //            rst   fr    faddr          lr    lwe   lock  laddr     lwdata
        //            fg    lg    men   mwe   maddr
        tbl.push_back(mk(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b1, 1'b0, 7'd8));
        tbl.push_back(mk(1'b1, 1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b0, 1'b1, 1'b1, 1'b0, 7'd0));
        tbl.push_back(mk(1'b1, 1'b1, 32'h28, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0,
                         1'b1, 1'b0, 1'b1, 1'b0, 7'd10));
        tbl.push_back(mk(1'b1, 1'b1, 32'h2C, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0,
                         1'b0, 1'b1, 1'b1, 1'b0, 7'd1));
        tbl.push_back(mk(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b1, 1'b0, 7'd4));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h08, 32'hDEADBEEF,
                         1'b0, 1'b1, 1'b1, 1'b1, 7'd2));
        tbl.push_back(mk(1'b1, 1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b1, 1'b0, 7'd2));
        tbl.push_back(mk(1'b1, 1'b1, 32'h06, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b0, 1'b0, 7'd0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h12345678,
                         1'b0, 1'b1, 1'b0, 1'b0, 7'd0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0,
                         1'b0, 1'b1, 1'b0, 1'b0, 7'd0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b0, 1'b1, 1'b1, 1'b0, 7'd0));
        tbl.push_back(mk(1'b1, 1'b1, 32'h1FC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b1, 1'b0, 7'd127));
        tbl.push_back(mk(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b0, 1'b0, 7'd0));
        tbl.push_back(mk(1'b1, 1'b1, 32'h8000_0010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b0, 1'b0, 7'd0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b0, 1'b0, 1'b0, 1'b0, 7'd0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'h0,
                         1'b0, 1'b1, 1'b1, 1'b0, 7'd3));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1FC, 32'h0,
                         1'b0, 1'b1, 1'b1, 1'b0, 7'd127));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0E, 32'hCAFE0000,
                         1'b0, 1'b1, 1'b0, 1'b0, 7'd0));
        tbl.push_back(mk(1'b1, 1'b1, 32'h0C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                         1'b1, 1'b0, 1'b1, 1'b0, 7'd3));
        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Lock: in-flight fetch completes, fetch starved until the unlock edge.
        apply_vec(mk(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 1'b0, 1'b1, 1'b0, 7'd5), "lk0");
        apply_vec(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h11111111,
                     1'b0, 1'b1, 1'b1, 1'b1, 7'd16), "lk1");
        apply_vec(mk(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h44, 32'h22222222,
                     1'b0, 1'b1, 1'b1, 1'b1, 7'd17), "lk2");
        apply_vec(mk(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h48, 32'h33333333,
                     1'b0, 1'b1, 1'b1, 1'b1, 7'd18), "lk3");
        apply_vec(mk(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 7'd0), "lk4");
        apply_vec(mk(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 7'd0), "lk5");
        apply_vec(mk(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 1'b0, 1'b1, 1'b0, 7'd4), "lk6");
        apply_vec(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0,
                     1'b0, 1'b1, 1'b1, 1'b0, 7'd17), "lk7");
        apply_vec(mk(1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 1'b0, 1'b1, 1'b0, 7'd18), "lk8");

        // Reset while locked: lock, round-robin and data holds return to reset state.
        apply_vec(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h50, 32'h00000005,
                     1'b0, 1'b1, 1'b1, 1'b1, 7'd20), "mr0");
        apply_vec(mk(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 7'd0), "mr1");
        apply_vec(mk(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0,
                     1'b1, 1'b0, 1'b1, 1'b0, 7'd4), "mr2");
        apply_vec(mk(1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0,
                     1'b0, 1'b1, 1'b1, 1'b0, 7'd16), "mr3");
        apply_vec(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 7'd0), "end0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
